// File: rtl/arm_register_file_if.sv
// Bundle of register-file datapath signals: Rd write port, PC/CPSR write
// ports and the Rn/Rm/Rs/PC/CPSR read results.
// master drives indices, data and enables; slave (the register file)
// returns the read values.
interface arm_register_file_if #(
    parameter int WORD_SIZE  = 32,
    parameter int ADDR_WIDTH = 4
);
    logic                  rd_we;
    logic [WORD_SIZE-1:0]  rd_in;
    logic [ADDR_WIDTH-1:0] write_rd;
    logic [ADDR_WIDTH-1:0] read_rn;
    logic [ADDR_WIDTH-1:0] read_rm;
    logic [ADDR_WIDTH-1:0] read_rs;
    logic [WORD_SIZE-1:0]  pc_in;
    logic [WORD_SIZE-1:0]  cpsr_in;
    logic                  pc_we;
    logic                  cpsr_we;
    logic [WORD_SIZE-1:0]  rn_out;
    logic [WORD_SIZE-1:0]  rm_out;
    logic [WORD_SIZE-1:0]  rs_out;
    logic [WORD_SIZE-1:0]  pc_out;
    logic [WORD_SIZE-1:0]  cpsr_out;

    modport master (
        output rd_we, rd_in, write_rd,
        output read_rn, read_rm, read_rs,
        output pc_in, cpsr_in, pc_we, cpsr_we,
        input  rn_out, rm_out, rs_out, pc_out, cpsr_out
    );

    modport slave (
        input  rd_we, rd_in, write_rd,
        input  read_rn, read_rm, read_rs,
        input  pc_in, cpsr_in, pc_we, cpsr_we,
        output rn_out, rm_out, rs_out, pc_out, cpsr_out
    );
endinterface

// File: rtl/arm_register_file.sv
// ARM-style register file: 16 x 32-bit GPRs with R15 aliased to the PC,
// plus a separate CPSR. Three asynchronous read ports, one synchronous Rd
// write port, dedicated PC and CPSR write ports.
// Ports: clk, reset (sync, active-high), bus (arm_register_file_if.slave).
module arm_register_file #(
    parameter int WORD_SIZE  = 32,
    parameter int NUM_REGS   = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int PC_INDEX   = 15
) (
    input logic                 clk,
    input logic                 reset,
    arm_register_file_if.slave  bus
);
    localparam logic [ADDR_WIDTH-1:0] PC_ADDR = ADDR_WIDTH'(PC_INDEX);

    // Entry PC_INDEX is the PC itself, so reads need no special aliasing.
    logic [WORD_SIZE-1:0] regs [NUM_REGS];
    logic [WORD_SIZE-1:0] cpsr;

    logic rd_hits_pc;
    assign rd_hits_pc = bus.rd_we && (bus.write_rd == PC_ADDR);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            cpsr <= '0;
        end else begin
            if (bus.rd_we) begin
                regs[bus.write_rd] <= bus.rd_in;
            end
            // An Rd write to R15 takes precedence over the PC port.
            if (bus.pc_we && !rd_hits_pc) begin
                regs[PC_ADDR] <= bus.pc_in;
            end
            if (bus.cpsr_we) begin
                cpsr <= bus.cpsr_in;
            end
        end
    end

    assign bus.rn_out   = regs[bus.read_rn];
    assign bus.rm_out   = regs[bus.read_rm];
    assign bus.rs_out   = regs[bus.read_rs];
    assign bus.pc_out   = regs[PC_ADDR];
    assign bus.cpsr_out = cpsr;
endmodule

// File: tb/tb_arm_register_file.sv
// Directed testbench for arm_register_file: reset, write sweep, read ports,
// PC aliasing/priority, CPSR and reset priority.
module tb_arm_register_file;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   errors  = 0;

    arm_register_file_if #(.WORD_SIZE(32), .ADDR_WIDTH(4)) bus ();

    arm_register_file dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rd_we    = 1'b0;
        bus.pc_we    = 1'b0;
        bus.cpsr_we  = 1'b0;
        bus.rd_in    = '0;
        bus.pc_in    = '0;
        bus.cpsr_in  = '0;
        bus.write_rd = '0;
    endtask

    initial begin
        logic [31:0] prev;
        reset       = 1'b0;
        idle();
        bus.read_rn = '0;
        bus.read_rm = '0;
        bus.read_rs = '0;
        tick();

        // 1. Fill everything with 42, then one reset edge clears it all.
        for (int i = 0; i < 16; i++) begin
            bus.rd_we    = 1'b1;
            bus.rd_in    = 32'd42;
            bus.write_rd = 4'(i);
            bus.cpsr_we  = 1'b1;
            bus.cpsr_in  = 32'd42;
            tick();
        end
        idle();
        bus.read_rn = 4'd7;
        #1;
        chk("fill_r7", bus.rn_out, 32'd42);
        chk("fill_pc", bus.pc_out, 32'd42);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.read_rn = 4'(i);
            bus.read_rm = 4'(15 - i);
            bus.read_rs = 4'(i);
            #1;
            chk($sformatf("rst_rn%0d", i), bus.rn_out, 32'd0);
            chk($sformatf("rst_rm%0d", 15 - i), bus.rm_out, 32'd0);
        end
        chk("rst_pc", bus.pc_out, 32'd0);
        chk("rst_cpsr", bus.cpsr_out, 32'd0);

        // 2. Sweep: no bypass, value appears only after the rising edge.
        for (int i = 0; i < 16; i++) begin
            bus.rd_we    = 1'b1;
            bus.rd_in    = 32'd42;
            bus.write_rd = 4'(i);
            bus.read_rn  = 4'(i);
            #1;
            chk($sformatf("sweep_pre%0d", i), bus.rn_out, 32'd0);
            @(negedge clk);
            prev = bus.rn_out;
            #2;
            chk($sformatf("sweep_neg%0d", i), bus.rn_out, prev);
            tick();
            chk($sformatf("sweep_post%0d", i), bus.rn_out, 32'd42);
        end
        idle();

        // 3. Three independent read ports.
        bus.rd_we = 1'b1;
        bus.write_rd = 4'd3; bus.rd_in = 32'd7;  tick();
        bus.write_rd = 4'd4; bus.rd_in = 32'd9;  tick();
        bus.write_rd = 4'd5; bus.rd_in = 32'd11; tick();
        idle();
        @(negedge clk);
        bus.read_rn = 4'd3;
        bus.read_rm = 4'd4;
        bus.read_rs = 4'd5;
        #1;
        chk("rn_r3", bus.rn_out, 32'd7);
        chk("rm_r4", bus.rm_out, 32'd9);
        chk("rs_r5", bus.rs_out, 32'd11);
        bus.read_rm = 4'd3;
        #1;
        chk("rm_r3", bus.rm_out, 32'd7);
        bus.read_rn = 4'd6;
        #1;
        chk("r6_untouched", bus.rn_out, 32'd42);

        // 4. PC alias and Rd-over-PC priority.
        tick();
        bus.pc_we = 1'b1;
        bus.pc_in = 32'h100;
        tick();
        idle();
        bus.read_rs = 4'd15;
        #1;
        chk("pc_load", bus.pc_out, 32'h100);
        chk("pc_r15", bus.rs_out, 32'h100);
        bus.rd_we    = 1'b1;
        bus.write_rd = 4'd15;
        bus.rd_in    = 32'h200;
        bus.pc_we    = 1'b1;
        bus.pc_in    = 32'h104;
        tick();
        idle();
        chk("pc_prio", bus.pc_out, 32'h200);
        chk("pc_prio_r15", bus.rs_out, 32'h200);
        tick();
        chk("pc_hold", bus.pc_out, 32'h200);
        bus.rd_we    = 1'b1;
        bus.write_rd = 4'd2;
        bus.rd_in    = 32'hDEAD_BEEF;
        bus.pc_we    = 1'b1;
        bus.pc_in    = 32'h300;
        tick();
        idle();
        bus.read_rn = 4'd2;
        #1;
        chk("pc_with_rd", bus.pc_out, 32'h300);
        chk("rd_with_pc", bus.rn_out, 32'hDEAD_BEEF);

        // 5. CPSR load and hold; GPRs unaffected.
        bus.cpsr_we = 1'b1;
        bus.cpsr_in = 32'hF000_0010;
        tick();
        chk("cpsr_load", bus.cpsr_out, 32'hF000_0010);
        bus.cpsr_we = 1'b0;
        bus.cpsr_in = 32'h1234_5678;
        tick();
        chk("cpsr_hold", bus.cpsr_out, 32'hF000_0010);
        chk("cpsr_gpr", bus.rn_out, 32'hDEAD_BEEF);
        chk("cpsr_pc", bus.pc_out, 32'h300);

        // 6. Reset overrides every enable.
        bus.rd_we    = 1'b1;
        bus.write_rd = 4'd2;
        bus.rd_in    = 32'h5555_AAAA;
        bus.pc_we    = 1'b1;
        bus.pc_in    = 32'h400;
        bus.cpsr_we  = 1'b1;
        bus.cpsr_in  = 32'hFFFF_FFFF;
        reset        = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        bus.read_rm = 4'd3;
        #1;
        chk("rp_r2", bus.rn_out, 32'd0);
        chk("rp_r3", bus.rm_out, 32'd0);
        chk("rp_pc", bus.pc_out, 32'd0);
        chk("rp_cpsr", bus.cpsr_out, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
